icb_dma_copy: RTL

//  ICB initiator (master) engine: copies a block of 32-bit words from a source to a destination address over one ICB master port.

---
 rtl/icb_dma_copy.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/icb_dma_copy.sv
// icb_dma_copy: ICB master engine that copies a block of 32-bit words.
// Define ICB_DMA_FILL_EN to add fill_mode/fill_data (pattern fill, no reads).
module icb_dma_copy #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
`ifdef ICB_DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_data,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             m_icb_cmd_valid,
    input  logic             m_icb_cmd_ready,
    output logic [31:0]      m_icb_cmd_addr,
    output logic             m_icb_cmd_read,
    output logic [31:0]      m_icb_cmd_wdata,
    output logic [3:0]       m_icb_cmd_wmask,
    input  logic             m_icb_rsp_valid,
    output logic             m_icb_rsp_ready,
    input  logic             m_icb_rsp_err,
    input  logic [31:0]      m_icb_rsp_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_CMD = 3'd1;
    localparam logic [2:0] S_RD_RSP = 3'd2;
    localparam logic [2:0] S_WR_CMD = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      data_q, data_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             fill_req;
    logic             fill_on;
    logic [31:0]      fill_word;
    logic             unused_addr_lsbs;

    // Byte offsets are dropped: the engine only moves whole words.
    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

`ifdef ICB_DMA_FILL_EN
    logic        fill_q, fill_d;
    logic [31:0] fdata_q, fdata_d;

    // Fill controls are captured together with the addresses at start.
    always_comb begin
        fill_d  = fill_q;
        fdata_d = fdata_q;
        if (state_q == S_IDLE && start) begin
            fill_d  = fill_mode;
            fdata_d = fill_data;
        end
    end

    // Fill control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q  <= 1'b0;
            fdata_q <= '0;
        end else begin
            fill_q  <= fill_d;
            fdata_q <= fdata_d;
        end
    end

    assign fill_req  = fill_mode;
    assign fill_on   = fill_q;
    assign fill_word = fdata_q;
`else
    assign fill_req  = 1'b0;
    assign fill_on   = 1'b0;
    assign fill_word = '0;
`endif

    // Next-state and datapath updates for the copy sequencer.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = {src_addr[31:2], 2'b00};
                    dst_d = {dst_addr[31:2], 2'b00};
                    cnt_d = len_words;
                    err_d = 1'b0;
                    if (len_words == '0) begin
                        state_d = S_FIN;
                    end else if (fill_req) begin
                        state_d = S_WR_CMD;
                    end else begin
                        state_d = S_RD_CMD;
                    end
                end
            end
            S_RD_CMD: begin
                if (m_icb_cmd_ready) begin
                    state_d = S_RD_RSP;
                end
            end
            S_RD_RSP: begin
                if (m_icb_rsp_valid) begin
                    data_d = m_icb_rsp_rdata;
                    if (m_icb_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_WR_CMD;
                    end
                end
            end
            S_WR_CMD: begin
                if (m_icb_cmd_ready) begin
                    dst_d = dst_q + 32'd4;
                    if (!fill_on) begin
                        src_d = src_q + 32'd4;
                    end
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_FIN;
                    end else if (fill_on) begin
                        state_d = S_WR_CMD;
                    end else begin
                        state_d = S_RD_CMD;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Bus and status outputs decode straight from the registered state.
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_FIN);
        err             = err_q;
        m_icb_cmd_valid = 1'b0;
        m_icb_cmd_read  = 1'b0;
        m_icb_cmd_addr  = '0;
        m_icb_cmd_wdata = '0;
        m_icb_cmd_wmask = 4'h0;
        m_icb_rsp_ready = (state_q == S_RD_RSP);
        if (state_q == S_RD_CMD) begin
            m_icb_cmd_valid = 1'b1;
            m_icb_cmd_read  = 1'b1;
            m_icb_cmd_addr  = src_q;
        end else if (state_q == S_WR_CMD) begin
            m_icb_cmd_valid = 1'b1;
            m_icb_cmd_addr  = dst_q;
            m_icb_cmd_wdata = fill_on ? fill_word : data_q;
            m_icb_cmd_wmask = 4'hF;
        end
    end

endmodule
